jk_target_driver: RTL
=====================

Name: jk_target_driver

Overview:
- Drives a WIDTH-bit bank of JK-style state bits from D-style requests: each command names a target or mask, and the block generates the J/K excitation that moves the bank there.
- Inverse of the JK-to-D conversion used in our flip-flop labs: this block converts desired next state into J/K drive.
- Sits between a command source (valid/ready) and any logic observing the bank state q and the applied j_out/k_out.

Parameters:
- WIDTH, 8, number of bits in the JK bank (1..32).
- SERIAL, 0, 0 = all bits excited in one cycle; 1 = one bit per cycle, bit 0 first.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- in_cmd  input  2  00 LOAD, 01 TOGGLE, 10 SET, 11 CLEAR.
- in_data  input  WIDTH  target (LOAD) or bit mask (others).
- j_out  output  WIDTH  J excitation applied this cycle.
- k_out  output  WIDTH  K excitation applied this cycle.
- q  output  WIDTH  current bank state.
- done  output  1  one-cycle pulse, operation complete.
- changed_cnt  output  $clog2(WIDTH+1)  number of bits of q changed by the last operation; valid while done=1, held until next accept.

Behaviour:
- Reset (async, rst_n=0): q=0, state IDLE, j_out=0, k_out=0, done=0, changed_cnt=0, bit index=0. in_ready=1 once reset is released.
- Reset asserted mid-operation aborts immediately with no partial completion. Bits of q already updated are cleared to 0.
- Bank update every clk edge, per bit: q_next = (j & ~q) | (~k & q).
  - j=k=1 toggles the bit.
  - Outside APPLY, j=k=0, so q holds.
- Excitation per command, with C = captured data and Q = q at the time of that bit's apply cycle:
  - LOAD: J = C & ~Q, K = ~C & Q (minimal excitation, don't-cares driven 0).
  - TOGGLE: J = K = C.
  - SET: J = C, K = 0.
  - CLEAR: J = 0, K = C.
- FSM has states IDLE, APPLY, DONE.
- IDLE:
  - in_ready=1.
  - in_valid & in_ready captures in_cmd/in_data, clears the change counter and bit index, and moves to APPLY.
- APPLY:
  - in_ready=0. in_valid is ignored (no capture, no error).
  - SERIAL=0: one cycle. j_out/k_out carry the full excitation vector; next state DONE.
  - SERIAL=1: WIDTH cycles. Only bit [index] of j_out/k_out may be nonzero; all other bits are 0. index increments each cycle, and after index=WIDTH-1 the FSM moves to DONE.
  - A bit needing no change still consumes its cycle, with j=k=0 on that bit.
- DONE:
  - done=1 for exactly one cycle. in_ready=0. j_out=k_out=0.
  - changed_cnt = total number of q bits that flipped during APPLY.
  - Next state IDLE.
- Latency from the accept edge:
  - SERIAL=0: done is high in the 2nd cycle after accept; the next accept is possible in the 3rd.
  - SERIAL=1: done is high in cycle WIDTH+1 after accept.
- j_out and k_out are combinational from state, captured data and q. q, done and changed_cnt are registered.
- Boundaries:
  - LOAD with target equal to q: j=k=0 everywhere, changed_cnt=0, done still pulses.
  - TOGGLE with mask all-ones: every bit flips, changed_cnt=WIDTH.
  - A zero mask for TOGGLE, SET or CLEAR is a legal no-op that completes with changed_cnt=0.
  - changed_cnt never wraps: its maximum is WIDTH.

Optional Feature:
- JK_PARITY_EN defined: adds output q_parity (1 bit) = XOR-reduce of q. It is combinational from registered q, and is 0 in reset.
- JK_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, SERIAL=0. After reset, LOAD 0xA5 -> in the APPLY cycle j_out=0xA5, k_out=0x00; then q=0xA5, done=1, changed_cnt=4 on the 2nd cycle after accept.
- From q=0xA5: TOGGLE 0x0F -> j_out=k_out=0x0F, q=0xAA, changed_cnt=4. Then SET 0x40 -> q=0xEA, changed_cnt=1. Then CLEAR 0xFF -> k_out=0xFF, q=0x00, changed_cnt=5.
- From q=0x3C: LOAD 0x3C -> j_out=k_out=0, q unchanged, done pulses, changed_cnt=0.
- SERIAL=1, WIDTH=8, from q=0: LOAD 0x81 -> cycle 1 has j_out=0x01 and q=0x01 after it; cycles 2-7 have j_out=0; cycle 8 has j_out=0x80 and q=0x81 after it; done at cycle 9; changed_cnt=2.
- Hold in_valid=1 with alternating commands during APPLY/DONE -> in_ready=0 and no capture; only the command present when in_ready=1 is taken.
- SERIAL=1, LOAD 0xFF, assert rst_n=0 after 3 apply cycles -> q=0, done=0, in_ready=1 after release, with no done pulse. With JK_PARITY_EN, q=0x07 before reset gives q_parity=1, and q_parity=0 after reset.

Source files
------------

// File: rtl/jk_target_driver.sv
// jk_target_driver: turns LOAD/TOGGLE/SET/CLEAR commands into J/K excitation for a WIDTH-bit JK bank.
// Define JK_PARITY_EN to add the q_parity output (XOR of the bank).
module jk_target_driver #(
  parameter int WIDTH = 8,
  parameter int SERIAL = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   in_cmd,
  input  logic [WIDTH-1:0]             in_data,
  output logic [WIDTH-1:0]             j_out,
  output logic [WIDTH-1:0]             k_out,
  output logic [WIDTH-1:0]             q,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   changed_cnt
`ifdef JK_PARITY_EN
  ,output logic                        q_parity
`endif
);
  localparam int CW = $clog2(WIDTH+1);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;
  state_t           state_q;
  logic [1:0]       cmd_q;
  logic [WIDTH-1:0] data_q, j_full, k_full, sel, q_d;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    flips;
  assign in_ready = state_q == IDLE;
`ifdef JK_PARITY_EN
  assign q_parity = ^q;
`endif
  always_comb begin
    // LOAD uses minimal excitation: only bits that must move get a J or K
    j_full = cmd_q == 2'b00 ? data_q & ~q : cmd_q == 2'b11 ? '0 : data_q;
    k_full = cmd_q == 2'b00 ? ~data_q & q : cmd_q == 2'b10 ? '0 : data_q;
    sel    = SERIAL != 0 ? WIDTH'(1) << idx_q : {WIDTH{1'b1}};
    j_out  = state_q == APPLY ? j_full & sel : '0;
    k_out  = state_q == APPLY ? k_full & sel : '0;
    q_d    = (j_out & ~q) | (~k_out & q);
    flips  = '0;
    for (int i = 0; i < WIDTH; i++) flips = flips + CW'(q_d[i] ^ q[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      idx_q       <= '0;
      q           <= '0;
      done        <= 1'b0;
      changed_cnt <= '0;
    end else begin
      q <= q_d;
      case (state_q)
        IDLE: if (in_valid) begin
          cmd_q       <= in_cmd;
          data_q      <= in_data;
          idx_q       <= '0;
          changed_cnt <= '0;
          state_q     <= APPLY;
        end
        APPLY: begin
          changed_cnt <= changed_cnt + flips;
          if (SERIAL == 0 || idx_q == IW'(WIDTH-1)) begin
            state_q <= DONE;
            done    <= 1'b1;
          end else idx_q <= idx_q + 1'b1;
        end
        default: begin
          state_q <= IDLE;
          done    <= 1'b0;
        end
      endcase
    end
  end
endmodule
